alu_multi: RTL and testbench
============================

Name: alu_multi

Overview:
- Parametrised successor to the single-accumulator 8-bit ALU.
- Holds NREGS accumulators of WIDTH bits and adds zero/carry flags, carry-chained add/subtract, and multi-cycle shifts (one bit per cycle).
- Accepts instructions over a valid/ready handshake and reports each result with a one-cycle valid pulse.
- Illegal opcodes trap into a sticky error state.

Parameters:
- WIDTH, 8: accumulator, immediate and result width (>=2).
- NREGS, 4: number of accumulators (>=2, power of two).
- SELW, clog2(NREGS): accumulator select width (derived, not overridden).

Ports:
- clock  in  1  sole clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- inst  in  4+SELW+WIDTH  {code[3:0], sel[SELW-1:0], imm[WIDTH-1:0]}.
- inst_valid  in  1  inst is presented this cycle.
- inst_ready  out  1  block can accept inst this cycle.
- err_clear  in  1  leave Error state; ignored in all other states.
- result  out  WIDTH  last value written to an accumulator.
- result_sel  out  SELW  index of the accumulator that result belongs to.
- result_valid  out  1  one-cycle pulse: result/result_sel/flags just updated.
- flag_zero  out  1  last written value == 0.
- flag_carry  out  1  carry / borrow / last bit shifted out.
- error  out  1  high while in Error state.

Behaviour:
- Reset (reset=0, async): accumulators, result, result_sel, flags, result_valid, error all 0; inst_ready=0; state=Reset; shift counter 0. Asserting reset mid-shift aborts immediately.
- States: Reset, Ready, Shift, Error.
- Reset state: first edge after reset release moves to Ready; inst_ready=0 throughout Reset.
- Ready: inst_ready=1. Accept occurs when inst_valid & inst_ready at an edge.
- Single-cycle ops write acc[sel] at the accept edge. result_valid=1 the following cycle with result=new value and result_sel=sel. Back-to-back accepts allowed every cycle.
- Opcodes (A=acc[sel], I=imm, C=flag_carry):
  - 0 NOP: no write, no result_valid, flags unchanged.
  - 1 LDI: A=I, C=0.
  - 2 ADD: A=A+I, C=carry out.
  - 3 SUB: A=A-I, C=borrow (A<I).
  - 4 NOT: A=~A, C=0.
  - 5 AND, 6 IOR, 7 XOR: A=A op I, C=0.
  - 8 SHL, 9 SHR: logical shift by I, vacated bits 0.
  - A ADC: A=A+I+C, C=carry out.
  - B SBC: A=A-I-C, C=borrow.
  - C-F: illegal.
- flag_zero is updated by every writing op.
- Arithmetic is modulo 2^WIDTH. Carry is computed in WIDTH+1 bits.
- Shifts: N=min(I,WIDTH).
  - N=0: behaves as a single-cycle op, A unchanged, C=0.
  - N>0: enter Shift at the accept edge; one bit per edge, N edges total, the first at the edge following accept. inst_ready=0 while in Shift.
  - C = last bit shifted out.
  - After the Nth shift edge: return to Ready, result_valid pulses.
  - Accept-to-result_valid latency is N+1 cycles.
- Illegal opcode at accept: go to Error, no accumulator or flag change, error=1, inst_ready=0, inst_valid ignored.
- Error: err_clear=1 at an edge returns to Ready; error deasserts the next cycle; accumulators and flags are retained. Only reset or err_clear leave Error.
- Between pulses, result, result_sel and flags hold their last values.
- inst contents are ignored whenever no accept occurs.

Test Plan (WIDTH=8, NREGS=4):
1. Hold reset=0, then release.
   -> All outputs 0; inst_ready=0 for one cycle, then 1.
2. LDI r1 0xF0, then ADD r1 0x20 back-to-back.
   -> Pulses: result 0xF0 (sel 1, C=0), then 0x10 (C=1, Z=0).
3. SUB r2 0x01 (r2=0), then SBC r2 0x00.
   -> 0xFF with C=1, then 0xFE with C=0.
4. LDI r0 0x81, then SHL r0 3.
   -> inst_ready low 3 cycles; result 0x08; C=0.
   Then SHR r0 200.
   -> 8 shift cycles; result 0x00; Z=1.
5. Issue opcode 0xD on r3.
   -> error=1, inst_ready=0, further inst_valid ignored.
   Pulse err_clear.
   -> Ready again; r1 still 0x10 (verify with ADD r1 0x00 -> 0x10).
6. Assert reset during SHL r0 5 cycle 2.
   -> Outputs go to reset values immediately, without waiting for a clock edge; after release, r0 reads 0.

Source files
------------

// File: rtl/alu_multi.sv
// Multi-accumulator ALU: NREGS accumulators of WIDTH bits, zero/carry flags,
// carry-chained add/subtract and bit-serial shifts, with a sticky error trap.
module alu_multi #(
  parameter int WIDTH = 8,
  parameter int NREGS = 4,
  localparam int SELW = $clog2(NREGS)
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [4+SELW+WIDTH-1:0]     inst,
  input  logic                        inst_valid,
  output logic                        inst_ready,
  input  logic                        err_clear,
  output logic [WIDTH-1:0]            result,
  output logic [SELW-1:0]             result_sel,
  output logic                        result_valid,
  output logic                        flag_zero,
  output logic                        flag_carry,
  output logic                        error,
  output logic [1:0]                  dbg_state
);

  localparam int CNTW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] WIDTH_IMM = WIDTH'(WIDTH);

  typedef enum logic [1:0] {S_RESET, S_READY, S_SHIFT, S_ERROR} state_t;
  state_t state, state_next;

  logic [3:0]       code;
  logic [SELW-1:0]  sel;
  logic [WIDTH-1:0] imm;
  logic [WIDTH-1:0] acc [NREGS];
  logic [WIDTH-1:0] a;
  logic             accept, illegal, is_shift, multi_shift;
  logic [CNTW-1:0]  shift_n;
  logic [WIDTH-1:0] op_val;
  logic             op_c, op_write;

  logic [WIDTH-1:0] sh_data, sh_next;
  logic [SELW-1:0]  sh_sel;
  logic             sh_left, sh_out;
  logic [CNTW-1:0]  sh_cnt;

  assign code = inst[4+SELW+WIDTH-1 -: 4];
  assign sel  = inst[WIDTH +: SELW];
  assign imm  = inst[WIDTH-1:0];
  assign a    = acc[sel];

  // Handshake: an instruction is taken on a rising edge where inst_valid and
  // inst_ready are both high; inst_ready depends only on the current state.
  assign accept      = inst_valid & inst_ready;
  assign illegal     = (code >= 4'hC);
  assign is_shift    = (code == 4'h8) || (code == 4'h9);
  assign shift_n     = (imm >= WIDTH_IMM) ? CNTW'(WIDTH) : CNTW'(imm);
  assign multi_shift = is_shift && (shift_n != '0);
  assign dbg_state   = state;

  assign sh_next = sh_left ? {sh_data[WIDTH-2:0], 1'b0} : {1'b0, sh_data[WIDTH-1:1]};
  assign sh_out  = sh_left ? sh_data[WIDTH-1] : sh_data[0];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= S_RESET;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    inst_ready = 1'b0;
    error      = 1'b0;
    case (state)
      S_RESET: state_next = S_READY;
      S_READY: begin
        inst_ready = 1'b1;
        if (accept) begin
          if (illegal)          state_next = S_ERROR;
          else if (multi_shift) state_next = S_SHIFT;
        end
      end
      S_SHIFT: if (sh_cnt == CNTW'(1)) state_next = S_READY;
      S_ERROR: begin
        error = 1'b1;
        if (err_clear) state_next = S_READY;
      end
      default: state_next = S_RESET;
    endcase
  end

  // Single-cycle result; a zero-length shift is treated as a plain write.
  always_comb begin
    op_val   = a;
    op_c     = 1'b0;
    op_write = 1'b1;
    case (code)
      4'h0: op_write = 1'b0;
      4'h1: op_val = imm;
      4'h2: {op_c, op_val} = {1'b0, a} + {1'b0, imm};
      4'h3: {op_c, op_val} = {1'b0, a} - {1'b0, imm};
      4'h4: op_val = ~a;
      4'h5: op_val = a & imm;
      4'h6: op_val = a | imm;
      4'h7: op_val = a ^ imm;
      4'h8, 4'h9: op_write = (shift_n == '0);
      4'hA: {op_c, op_val} = {1'b0, a} + {1'b0, imm} + {{WIDTH{1'b0}}, flag_carry};
      4'hB: {op_c, op_val} = {1'b0, a} - {1'b0, imm} - {{WIDTH{1'b0}}, flag_carry};
      default: op_write = 1'b0;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) acc[i] <= '0;
      result       <= '0;
      result_sel   <= '0;
      result_valid <= 1'b0;
      flag_zero    <= 1'b0;
      flag_carry   <= 1'b0;
      sh_data      <= '0;
      sh_sel       <= '0;
      sh_left      <= 1'b0;
      sh_cnt       <= '0;
    end else begin
      result_valid <= 1'b0;
      if (accept && op_write) begin
        acc[sel]     <= op_val;
        result       <= op_val;
        result_sel   <= sel;
        flag_zero    <= (op_val == '0);
        flag_carry   <= op_c;
        result_valid <= 1'b1;
      end
      if (accept && multi_shift) begin
        sh_data <= a;
        sh_sel  <= sel;
        sh_left <= (code == 4'h8);
        sh_cnt  <= shift_n;
      end
      // Flags and result stay frozen until the final shift step.
      if (state == S_SHIFT) begin
        sh_data <= sh_next;
        sh_cnt  <= sh_cnt - 1'b1;
        if (sh_cnt == CNTW'(1)) begin
          acc[sh_sel]  <= sh_next;
          result       <= sh_next;
          result_sel   <= sh_sel;
          flag_zero    <= (sh_next == '0);
          flag_carry   <= sh_out;
          result_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_multi.sv
// Bench for alu_multi (WIDTH=8, NREGS=4): directed vectors with literal
// expectations plus a cycle-level reference model checked every cycle.
module tb_alu_multi;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [13:0] inst = '0;
  logic        inst_valid = 1'b0;
  logic        err_clear = 1'b0;
  logic        inst_ready, result_valid, flag_zero, flag_carry, error;
  logic [7:0]  result;
  logic [1:0]  result_sel;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  alu_multi #(.WIDTH(8), .NREGS(4)) dut (
    .clock(clock), .reset(reset), .inst(inst), .inst_valid(inst_valid),
    .inst_ready(inst_ready), .err_clear(err_clear), .result(result),
    .result_sel(result_sel), .result_valid(result_valid),
    .flag_zero(flag_zero), .flag_carry(flag_carry), .error(error),
    .dbg_state(dbg_state)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: whole-instruction arithmetic, shifts done in one step
  // and released after N cycles.
  int m_acc [4];
  bit m_boot, m_err, m_valid, m_z, m_c;
  int m_busy, m_pend_val, m_pend_sel, m_result, m_sel;
  bit m_pend_c;

  task automatic m_write(input int s, input int v, input bit c);
    m_acc[s] = v;
    m_result = v;
    m_sel    = s;
    m_z      = (v == 0);
    m_c      = c;
    m_valid  = 1'b1;
  endtask

  task automatic m_exec(input logic [3:0] code, input int s, input int imm);
    int a, r, n;
    a = m_acc[s];
    case (code)
      4'h0: ;
      4'h1: m_write(s, imm, 1'b0);
      4'h2: begin r = a + imm; m_write(s, r % 256, r > 255); end
      4'h3: begin r = a - imm; m_write(s, (r + 256) % 256, r < 0); end
      4'h4: m_write(s, 255 - a, 1'b0);
      4'h5: m_write(s, a & imm, 1'b0);
      4'h6: m_write(s, a | imm, 1'b0);
      4'h7: m_write(s, a ^ imm, 1'b0);
      4'h8, 4'h9: begin
        n = (imm > 8) ? 8 : imm;
        if (n == 0) m_write(s, a, 1'b0);
        else begin
          if (code == 4'h8) begin
            m_pend_val = (a << n) & 255;
            m_pend_c   = bit'((a >> (8 - n)) & 1);
          end else begin
            m_pend_val = a >> n;
            m_pend_c   = bit'((a >> (n - 1)) & 1);
          end
          m_pend_sel = s;
          m_busy     = n;
        end
      end
      4'hA: begin r = a + imm + int'(m_c); m_write(s, r % 256, r > 255); end
      4'hB: begin r = a - imm - int'(m_c); m_write(s, (r + 256) % 256, r < 0); end
      default: m_err = 1'b1;
    endcase
  endtask

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) m_acc[i] = 0;
      m_boot = 1'b1; m_err = 1'b0; m_valid = 1'b0; m_z = 1'b0; m_c = 1'b0;
      m_busy = 0; m_result = 0; m_sel = 0;
    end else begin
      m_valid = 1'b0;
      if (m_boot) m_boot = 1'b0;
      else if (m_err) begin
        if (err_clear) m_err = 1'b0;
      end else if (m_busy > 0) begin
        m_busy--;
        if (m_busy == 0) m_write(m_pend_sel, m_pend_val, m_pend_c);
      end else if (inst_valid) m_exec(inst[13:10], int'(inst[9:8]), int'(inst[7:0]));
    end
  end

  always @(negedge clock) begin
    if (cmp_en) begin
      check("inst_ready", inst_ready, reset && !m_boot && !m_err && m_busy == 0);
      check("error", error, m_err);
      check("result_valid", result_valid, m_valid);
      check("result", result, m_result);
      check("result_sel", result_sel, m_sel);
      check("flag_zero", flag_zero, m_z);
      check("flag_carry", flag_carry, m_c);
    end
  end

  task automatic drive(input logic [3:0] code, input logic [1:0] s, input logic [7:0] imm);
    inst = {code, s, imm};
    inst_valid = 1'b1;
    @(negedge clock);
    inst_valid = 1'b0;
    inst = 14'($urandom_range(0, 16383));
  endtask

  task automatic wait_pulse(input int max, output int waited);
    waited = 0;
    while (!result_valid && waited < max) begin
      @(negedge clock);
      waited++;
    end
    if (!result_valid) check("pulse_timeout", 0, 1);
  endtask

  task automatic pin(input string name, input logic [7:0] r, input logic [1:0] s, input bit z, input bit c);
    check({name, "_valid"}, result_valid, 1);
    check({name, "_result"}, result, r);
    check({name, "_sel"}, result_sel, s);
    check({name, "_zero"}, flag_zero, z);
    check({name, "_carry"}, flag_carry, c);
  endtask

  initial begin
    int w;
    #2 reset = 1'b0;
    #1;
    check("rst_result", result, 0);
    check("rst_ready", inst_ready, 0);
    check("rst_error", error, 0);
    check("rst_flags", {flag_zero, flag_carry, result_valid}, 0);
    cmp_en = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    check("boot_ready_low", inst_ready, 0);
    @(negedge clock);
    check("boot_ready_high", inst_ready, 1);

    drive(4'h1, 2'd1, 8'hF0);  pin("ldi_r1", 8'hF0, 2'd1, 1'b0, 1'b0);
    drive(4'h2, 2'd1, 8'h20);  pin("add_r1", 8'h10, 2'd1, 1'b0, 1'b1);

    drive(4'h3, 2'd2, 8'h01);  pin("sub_r2", 8'hFF, 2'd2, 1'b0, 1'b1);
    drive(4'hB, 2'd2, 8'h00);  pin("sbc_r2", 8'hFE, 2'd2, 1'b0, 1'b0);

    drive(4'h1, 2'd0, 8'h81);  pin("ldi_r0", 8'h81, 2'd0, 1'b0, 1'b0);
    drive(4'h8, 2'd0, 8'd3);
    check("shl_ready_low", inst_ready, 0);
    wait_pulse(20, w);
    check("shl_latency", w, 3);
    pin("shl_r0", 8'h08, 2'd0, 1'b0, 1'b0);
    drive(4'h9, 2'd0, 8'd200);
    wait_pulse(20, w);
    check("shr200_latency", w, 8);
    pin("shr200_r0", 8'h00, 2'd0, 1'b1, 1'b0);

    drive(4'hD, 2'd3, 8'h55);
    check("trap_error", error, 1);
    check("trap_ready", inst_ready, 0);
    inst = {4'h1, 2'd1, 8'h55};
    inst_valid = 1'b1;
    repeat (3) @(negedge clock);
    inst_valid = 1'b0;
    check("trap_hold_error", error, 1);
    check("trap_hold_result", result, 8'h00);
    err_clear = 1'b1;
    @(negedge clock);
    err_clear = 1'b0;
    check("clear_error", error, 0);
    check("clear_ready", inst_ready, 1);
    drive(4'h2, 2'd1, 8'h00);  pin("r1_kept", 8'h10, 2'd1, 1'b0, 1'b0);

    drive(4'h1, 2'd3, 8'h5A);  pin("ldi_r3", 8'h5A, 2'd3, 1'b0, 1'b0);
    drive(4'h4, 2'd3, 8'h00);  pin("not_r3", 8'hA5, 2'd3, 1'b0, 1'b0);
    drive(4'h5, 2'd3, 8'h0F);  pin("and_r3", 8'h05, 2'd3, 1'b0, 1'b0);
    drive(4'h6, 2'd3, 8'hF0);  pin("ior_r3", 8'hF5, 2'd3, 1'b0, 1'b0);
    drive(4'h7, 2'd3, 8'hFF);  pin("xor_r3", 8'h0A, 2'd3, 1'b0, 1'b0);
    drive(4'h0, 2'd3, 8'h77);
    check("nop_valid", result_valid, 0);
    check("nop_result", result, 8'h0A);
    drive(4'h9, 2'd3, 8'd0);   pin("shr0_r3", 8'h0A, 2'd3, 1'b0, 1'b0);
    drive(4'h1, 2'd2, 8'hFF);  pin("ldi_r2", 8'hFF, 2'd2, 1'b0, 1'b0);
    drive(4'h2, 2'd2, 8'h01);  pin("add_wrap", 8'h00, 2'd2, 1'b1, 1'b1);
    drive(4'hA, 2'd2, 8'h05);  pin("adc_r2", 8'h06, 2'd2, 1'b0, 1'b0);
    drive(4'h3, 2'd2, 8'h07);  pin("sub_borrow", 8'hFF, 2'd2, 1'b0, 1'b1);
    drive(4'hB, 2'd2, 8'h00);  pin("sbc_borrow", 8'hFE, 2'd2, 1'b0, 1'b0);
    drive(4'h9, 2'd2, 8'd9);
    wait_pulse(20, w);
    check("shr9_latency", w, 8);
    pin("shr9_r2", 8'h00, 2'd2, 1'b1, 1'b1);

    drive(4'h1, 2'd0, 8'h03);  pin("ldi_r0b", 8'h03, 2'd0, 1'b0, 1'b0);
    drive(4'h8, 2'd0, 8'd5);
    @(posedge clock);
    #2 reset = 1'b0;
    #1;
    check("abort_result", result, 0);
    check("abort_sel", result_sel, 0);
    check("abort_ready", inst_ready, 0);
    check("abort_flags", {flag_zero, flag_carry, result_valid, error}, 0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("abort_ready_again", inst_ready, 1);
    drive(4'h2, 2'd0, 8'h00);  pin("r0_cleared", 8'h00, 2'd0, 1'b1, 1'b0);

    @(negedge clock);
    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
